// File: rtl/router_pkg.sv
// Definitions shared between the router and its port sinks: header field slices,
// the sink FSM state encoding and the running-parity helper.
package router_pkg;

    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 2;
    localparam int ADDR_MSB = 1;
    localparam int ADDR_LSB = 0;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } sink_state_e;

    function automatic logic [7:0] parity_xor(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/router_port_sink_if.sv
// Router output-port FIFO handshake plus the framed byte stream re-emitted by the sink.
interface router_port_sink_if;

    logic       vld_out;
    logic [7:0] data_out;
    logic       read_enb;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_sop;
    logic       byte_eop;

    // master: the router port side (drives FIFO status/data, observes the stream)
    modport master (
        output vld_out,
        output data_out,
        input  read_enb,
        input  byte_out,
        input  byte_valid,
        input  byte_sop,
        input  byte_eop
    );

    // slave: the sink that pops the FIFO and emits the framed stream
    modport slave (
        input  vld_out,
        input  data_out,
        output read_enb,
        output byte_out,
        output byte_valid,
        output byte_sop,
        output byte_eop
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/router_port_sink.sv
// Drains one router output port packet by packet, re-emits each byte as a framed
// stream, checks parity and destination, and keeps saturating packet/error counts.
module router_port_sink
    import router_pkg::*;
#(
    parameter logic [1:0]  PORT_ID = 2'd0,
    parameter int unsigned TIMEOUT = 32,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    router_port_sink_if.slave port,
    output logic              pkt_done,
    output logic [5:0]        pkt_len,
    output logic              parity_err,
    output logic              addr_err,
    output logic              trunc_err,
    output logic [CNT_W-1:0]  pkt_count,
    output logic [CNT_W-1:0]  err_count
);

    sink_state_e state_q;
    logic [6:0]  issued_q;
    logic [6:0]  cap_idx_q;
    logic [7:0]  acc_q;
    logic [7:0]  byte_q;
    logic [5:0]  len_q;
    logic [1:0]  addr_q;
    logic        hdr_seen_q;
    logic        pop_q;
    logic [31:0] stall_q;

    logic [6:0]  limit;
    logic [6:0]  last_idx;
    logic        timeout_hit;
    logic        pop;
    logic        last_cap;
    logic        pkt_ok;
    logic        inc_pkt;
    logic        inc_err;

    // Until the header is in hand only header + parity are known to exist, so at most
    // two pops may be in flight; after that the real length bounds the issue count.
    always_comb begin
        limit       = hdr_seen_q ? ({1'b0, len_q} + 7'd2) : 7'd2;
        last_idx    = {1'b0, len_q} + 7'd1;
        timeout_hit = (state_q == StRun) && (stall_q >= TIMEOUT);
        pop         = (state_q == StRun) && port.vld_out && (issued_q < limit) && !timeout_hit;
        last_cap    = pop_q && hdr_seen_q && (cap_idx_q == last_idx);
    end

    assign port.read_enb   = pop;
    assign port.byte_valid = pop_q;
    assign port.byte_out   = pop_q ? port.data_out : byte_q;
    assign port.byte_sop   = pop_q && !hdr_seen_q;
    assign port.byte_eop   = last_cap;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            issued_q   <= '0;
            cap_idx_q  <= '0;
            acc_q      <= '0;
            byte_q     <= '0;
            len_q      <= '0;
            addr_q     <= '0;
            hdr_seen_q <= 1'b0;
            pop_q      <= 1'b0;
            stall_q    <= '0;
            pkt_done   <= 1'b0;
            pkt_len    <= '0;
            parity_err <= 1'b0;
            addr_err   <= 1'b0;
            trunc_err  <= 1'b0;
        end else begin
            pop_q    <= pop;
            pkt_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    issued_q   <= '0;
                    cap_idx_q  <= '0;
                    acc_q      <= '0;
                    hdr_seen_q <= 1'b0;
                    stall_q    <= '0;
                    if (enable && port.vld_out) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (pop) begin
                        issued_q <= issued_q + 7'd1;
                        stall_q  <= '0;
                    end else if (!port.vld_out && !pop_q) begin
                        stall_q <= stall_q + 32'd1;
                    end
                    if (pop_q) begin
                        byte_q    <= port.data_out;
                        cap_idx_q <= cap_idx_q + 7'd1;
                        if (!hdr_seen_q) begin
                            len_q      <= port.data_out[LEN_MSB:LEN_LSB];
                            addr_q     <= port.data_out[ADDR_MSB:ADDR_LSB];
                            acc_q      <= port.data_out;
                            hdr_seen_q <= 1'b1;
                        end else if (last_cap) begin
                            parity_err <= (port.data_out != acc_q);
                            addr_err   <= (addr_q != PORT_ID);
                            trunc_err  <= 1'b0;
                            pkt_len    <= len_q;
                            pkt_done   <= 1'b1;
                            state_q    <= StDone;
                        end else begin
                            acc_q <= parity_xor(acc_q, port.data_out);
                        end
                    end else if (timeout_hit) begin
                        // Abandon the packet; whatever is left in the FIFO stays there.
                        parity_err <= 1'b0;
                        addr_err   <= hdr_seen_q && (addr_q != PORT_ID);
                        trunc_err  <= 1'b1;
                        pkt_len    <= hdr_seen_q ? len_q : 6'd0;
                        pkt_done   <= 1'b1;
                        state_q    <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Flags were registered on entry to DONE, so they are stable for the counter update.
    assign pkt_ok  = !(parity_err || addr_err || trunc_err);
    assign inc_pkt = (state_q == StDone) && pkt_ok;
    assign inc_err = (state_q == StDone) && !pkt_ok;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_pkt_counter (
        .clock (clock),
        .reset (reset),
        .inc   (inc_pkt),
        .count (pkt_count)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_err_counter (
        .clock (clock),
        .reset (reset),
        .inc   (inc_err),
        .count (err_count)
    );

endmodule

// File: tb/tb_router_port_sink.sv
// Randomised scoreboard bench for router_port_sink with a queue-based router FIFO model.
module tb_router_port_sink;

    localparam logic [1:0] PORT_ID = 2'd2;
    localparam int         TIMEOUT = 32;
    localparam int         CNT_W   = 3;
    localparam int         CNT_MAX = (1 << CNT_W) - 1;

    logic             clock  = 1'b0;
    logic             reset  = 1'b1;
    logic             enable = 1'b0;
    logic             pkt_done;
    logic [5:0]       pkt_len;
    logic             parity_err;
    logic             addr_err;
    logic             trunc_err;
    logic [CNT_W-1:0] pkt_count;
    logic [CNT_W-1:0] err_count;

    router_port_sink_if port ();

    router_port_sink #(
        .PORT_ID (PORT_ID),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .port       (port),
        .pkt_done   (pkt_done),
        .pkt_len    (pkt_len),
        .parity_err (parity_err),
        .addr_err   (addr_err),
        .trunc_err  (trunc_err),
        .pkt_count  (pkt_count),
        .err_count  (err_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] b;
        bit         sop;
        bit         eop;
    } beat_t;

    typedef struct {
        int len;
        bit par;
        bit adr;
        bit trn;
        bit steady;
        int npops;
        int pkts;
        int errs;
    } res_t;

    beat_t      exp_beats[$];
    res_t       exp_res[$];
    logic [7:0] fifo[$];

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;
    int pops       = 0;
    int pops_base  = 0;
    int first_pop  = 0;
    int last_pop   = 0;
    int done_seen  = 0;
    int beats_seen = 0;
    int model_pkts = 0;
    int model_errs = 0;
    bit cnt_check  = 0;
    int cnt_exp_p  = 0;
    int cnt_exp_e  = 0;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    // Router FIFO: data_out updates the edge after a pop, vld_out mirrors non-empty.
    initial begin
        forever begin
            @(posedge clock);
            if (reset) begin
                port.vld_out  <= 1'b0;
                port.data_out <= 8'h00;
            end else begin
                if (port.read_enb) begin
                    check("pop_when_empty", int'(fifo.size() == 0), 0);
                    if (pops == pops_base) first_pop = cycle;
                    last_pop = cycle;
                    pops++;
                    if (fifo.size() != 0) port.data_out <= fifo.pop_front();
                end
                port.vld_out <= (fifo.size() != 0);
            end
            cycle++;
        end
    end

    // Monitor: compares every emitted byte and every pkt_done against the scoreboard.
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                pops_base = pops;
                cnt_check = 0;
            end else begin
                if (cnt_check) begin
                    check("pkt_count", int'(pkt_count), cnt_exp_p);
                    check("err_count", int'(err_count), cnt_exp_e);
                    cnt_check = 0;
                end
                if (port.byte_valid) begin
                    if (exp_beats.size() == 0) begin
                        check("unexpected_byte", 1, 0);
                    end else begin
                        check("byte_out", int'(port.byte_out), int'(exp_beats[0].b));
                        check("byte_sop", int'(port.byte_sop), int'(exp_beats[0].sop));
                        check("byte_eop", int'(port.byte_eop), int'(exp_beats[0].eop));
                        void'(exp_beats.pop_front());
                    end
                    beats_seen++;
                end
                if (pkt_done) begin
                    if (exp_res.size() == 0) begin
                        check("unexpected_pkt_done", 1, 0);
                    end else begin
                        check("parity_err", int'(parity_err), int'(exp_res[0].par));
                        check("addr_err", int'(addr_err), int'(exp_res[0].adr));
                        check("trunc_err", int'(trunc_err), int'(exp_res[0].trn));
                        check("pops_per_pkt", pops - pops_base, exp_res[0].npops);
                        if (!exp_res[0].trn) begin
                            check("pkt_len", int'(pkt_len), exp_res[0].len);
                            check("done_after_last_pop", cycle - last_pop, 2);
                        end
                        if (exp_res[0].steady) begin
                            check("pop_span", last_pop - first_pop, exp_res[0].npops - 1);
                        end
                        cnt_exp_p = exp_res[0].pkts;
                        cnt_exp_e = exp_res[0].errs;
                        cnt_check = 1;
                        void'(exp_res.pop_front());
                    end
                    pops_base = pops;
                    done_seen++;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        fifo.delete();
        exp_beats.delete();
        exp_res.delete();
        model_pkts = 0;
        model_errs = 0;
        @(negedge clock);
        check("rst_read_enb", int'(port.read_enb), 0);
        check("rst_byte_valid", int'(port.byte_valid), 0);
        check("rst_byte_sop", int'(port.byte_sop), 0);
        check("rst_byte_eop", int'(port.byte_eop), 0);
        check("rst_byte_out", int'(port.byte_out), 0);
        check("rst_pkt_done", int'(pkt_done), 0);
        check("rst_flags", int'({parity_err, addr_err, trunc_err}), 0);
        check("rst_pkt_len", int'(pkt_len), 0);
        check("rst_pkt_count", int'(pkt_count), 0);
        check("rst_err_count", int'(err_count), 0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // stall_at >= 0: push header + stall_at payload bytes, let the FIFO run dry, then
    // either push the rest after stall_len cycles or (cut) never send it.
    task automatic send_pkt(input logic [7:0] hdr, input bit bad_par, input int stall_at,
                            input int stall_len, input bit cut, input int en_delay,
                            input bit drop_en);
        logic [7:0] bytes[$];
        logic [7:0] par;
        logic [7:0] b;
        int         len;
        int         npush;
        int         base;
        int         beat_base;
        int         waited;
        beat_t      bt;
        res_t       rs;
        len = int'(hdr[7:2]);
        par = hdr;
        bytes.push_back(hdr);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            bytes.push_back(b);
            par = par ^ b;
        end
        bytes.push_back(bad_par ? (par ^ 8'h01) : par);
        npush = cut ? (1 + stall_at) : (len + 2);
        for (int i = 0; i < npush; i++) begin
            bt.b   = bytes[i];
            bt.sop = (i == 0);
            bt.eop = (i == len + 1);
            exp_beats.push_back(bt);
        end
        rs.len    = len;
        rs.par    = !cut && bad_par;
        rs.adr    = (hdr[1:0] != PORT_ID);
        rs.trn    = cut;
        rs.steady = (stall_at < 0);
        rs.npops  = npush;
        if (rs.par || rs.adr || rs.trn) model_errs = sat_inc(model_errs);
        else model_pkts = sat_inc(model_pkts);
        rs.pkts = model_pkts;
        rs.errs = model_errs;
        exp_res.push_back(rs);
        base      = done_seen;
        beat_base = beats_seen;
        if (en_delay > 0) enable = 1'b0;
        if (stall_at < 0) begin
            for (int i = 0; i < npush; i++) fifo.push_back(bytes[i]);
        end else begin
            for (int i = 0; i <= stall_at; i++) fifo.push_back(bytes[i]);
            waited = 0;
            while (fifo.size() != 0 && waited < 500) begin
                @(negedge clock);
                waited++;
            end
            if (!cut) begin
                repeat (stall_len) @(negedge clock);
                for (int i = stall_at + 1; i < len + 2; i++) fifo.push_back(bytes[i]);
            end
        end
        if (en_delay > 0) begin
            repeat (en_delay) @(negedge clock);
            check("no_pop_while_disabled", pops - pops_base, 0);
            enable = 1'b1;
        end
        waited = 0;
        while (done_seen == base && waited < 1000) begin
            @(negedge clock);
            waited++;
            if (drop_en && beats_seen != beat_base) enable = 1'b0;
        end
        enable = 1'b1;
        if (done_seen == base) begin
            check("pkt_done_timeout", 0, 1);
            do_reset();
        end else begin
            repeat (2) @(negedge clock);
        end
    endtask

    initial begin
        int         len;
        int         stall_at;
        logic [1:0] addr;
        int         waited;
        int         beat_base;
        logic [7:0] hdr;

        do_reset();
        enable = 1'b1;

        send_pkt(8'h22, 1'b0, -1, 0, 1'b0, 0, 1'b0);   // good, len 8
        send_pkt(8'h22, 1'b1, -1, 0, 1'b0, 0, 1'b0);   // parity corrupted
        send_pkt(8'h15, 1'b0, -1, 0, 1'b0, 0, 1'b0);   // wrong address, still drained
        send_pkt(8'h02, 1'b0, -1, 0, 1'b0, 0, 1'b0);   // len 0
        send_pkt(8'h22, 1'b0, 3, 0, 1'b1, 0, 1'b0);    // truncated after 3 payload bytes
        check("read_enb_after_trunc", int'(port.read_enb), 0);
        send_pkt(8'h22, 1'b0, 3, 15, 1'b0, 0, 1'b0);   // stall shorter than timeout

        // Reset in the middle of a packet's payload.
        hdr = 8'h22;
        fifo.push_back(hdr);
        exp_beats.push_back('{b: hdr, sop: 1'b1, eop: 1'b0});
        for (int i = 0; i < 9; i++) begin
            fifo.push_back(8'($urandom));
            exp_beats.push_back('{b: fifo[fifo.size() - 1], sop: 1'b0, eop: (i == 8)});
        end
        beat_base = beats_seen;
        waited    = 0;
        while (beats_seen < beat_base + 4 && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        check("beats_before_reset", int'(beats_seen >= beat_base + 4), 1);
        do_reset();
        send_pkt(8'h22, 1'b0, -1, 0, 1'b0, 0, 1'b0);   // counters restart from zero

        send_pkt(8'h22, 1'b0, -1, 0, 1'b0, 20, 1'b0);  // held off by enable = 0
        send_pkt(8'h1e, 1'b0, -1, 0, 1'b0, 0, 1'b1);   // enable dropped mid-packet

        for (int n = 0; n < 24; n++) begin
            len      = $urandom_range(0, 63);
            addr     = ($urandom_range(0, 3) == 0) ? 2'($urandom) : PORT_ID;
            stall_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len) : -1;
            send_pkt({6'(len), addr}, ($urandom_range(0, 4) == 0), stall_at,
                     $urandom_range(1, 20), 1'b0, 0, ($urandom_range(0, 3) == 0));
        end

        repeat (4) @(negedge clock);
        check("leftover_beats", exp_beats.size(), 0);
        check("leftover_results", exp_res.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched",
                 compared, mismatched);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/router_port_sink.md
# router_port_sink

Downstream consumer for one router output port. It drains packets from the port's FIFO interface (vld_out/read_enb/data_out) and parses the header, payload and parity. It re-emits each byte as a framed stream and checks the parity and destination address. It also keeps packet and error counters. One instance sits on each of output ports 0–2 and replaces bench-driven read_enb in integration and system tests.

## Interface
- PORT_ID, 2'd0, port this instance drains; header bits [1:0] must equal it
- TIMEOUT, 32, max consecutive cycles vld_out may stay low mid-packet before abort
- CNT_W, 16, width of the packet and error counters
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- enable  in  1  allows a new packet to be started; sampled only in IDLE
- vld_out  in  1  router port has data (FIFO not empty)
- data_out  in  8  router port byte, valid the cycle after a read_enb pop
- read_enb  out  1  pop request to the router port
- byte_out  out  8  captured byte
- byte_valid  out  1  byte_out valid this cycle
- byte_sop  out  1  byte_out is the header
- byte_eop  out  1  byte_out is the parity byte
- pkt_done  out  1  one-cycle pulse after the parity byte is checked or the packet is aborted
- pkt_len  out  6  payload length of the last completed packet
- parity_err  out  1  sticky-per-packet: parity mismatch, valid with pkt_done
- addr_err  out  1  header address ≠ PORT_ID, valid with pkt_done
- trunc_err  out  1  packet aborted by timeout, valid with pkt_done
- pkt_count  out  CNT_W  packets completed without error, saturating
- err_count  out  CNT_W  packets with any error, saturating

## Operation
- Packet format: header {len[5:0], addr[1:0]}, then len payload bytes, then one parity byte. Parity = XOR of header and all payload bytes. len = 0 is legal, giving 2 bytes total.
- FSM has three states: IDLE, RUN, DONE.
- IDLE: read_enb = 0. Moves to RUN when enable & vld_out. The issue count, capture count and parity accumulator are cleared.
- RUN: read_enb = vld_out & (issued < limit), and is combinational.
  - limit = 2 until the header is captured, then len + 2.
  - Each pop increments issued.
  - The captured byte index is a counter over captured bytes.
  - Index 0: latch len and addr, acc = byte, byte_sop = 1.
  - Indexes 1..len: acc ^= byte.
  - Index len + 1: compare with acc, byte_eop = 1, go to DONE.
- Stall timeout: a stall counter counts cycles in RUN with vld_out = 0 and no capture pending. It resets on any pop. If it reaches TIMEOUT, trunc_err is set, read_enb = 0 and the FSM goes to DONE. Bytes still in the FIFO are not drained.
- DONE: lasts one cycle.
  - pkt_done = 1.
  - pkt_len and the three error flags update.
  - Exactly one counter increments, saturating at all-ones.
  - Returns to IDLE.
- enable deasserted mid-packet has no effect; the current packet completes.
- Error flags and pkt_len hold until the next pkt_done.

## Timing
- Reset values:
  - read_enb, byte_valid, byte_sop, byte_eop, pkt_done, all error flags: 0.
  - byte_out, pkt_len, counters: 0.
  - FSM: IDLE.
- Pop-to-capture latency is exactly 1 cycle: byte_valid(t+1) = read_enb(t).
- The first read_enb comes 1 cycle after enable & vld_out are seen in IDLE.
- With vld_out held high, a packet of len N produces N+2 consecutive pops. pkt_done follows 2 cycles after the last pop.
- Back-to-back packets: minimum 1 IDLE cycle between the last pop and the next first pop.
- pops never exceed len + 2:
  - Pops 1 and 2 may issue before the header is seen.
  - For len = 0, issuing stops after pop 2.
- Reset asserted mid-packet: immediate return to reset values; the partial packet is not counted.

## Structure
- Package router_pkg holds the following, shared with the router:
  - header field slices: LEN_MSB = 7, LEN_LSB = 2, ADDR_MSB = 1, ADDR_LSB = 0.
  - the FSM state encoding.
  - a parity XOR function.
- One sub-module, sat_counter (CNT_W, increment, saturate), instantiated twice.

## Test plan
- PORT_ID = 2, header 8'h22 (len 8, addr 2), 8 random bytes, correct parity, vld_out steady → 10 pops; pkt_done with pkt_len = 8, no errors, pkt_count = 1.
- Same packet with the parity byte XORed with 8'h01 → parity_err = 1, err_count = 1, pkt_count unchanged.
- PORT_ID = 1, header 8'h16 (len 5, addr 2) → addr_err = 1; all 7 bytes still drained.
- Header 8'h02 (len 0) → exactly 2 pops, pkt_len = 0, byte_sop and byte_eop on consecutive cycles.
- vld_out dropped after 3 payload bytes and held low for 32 cycles → trunc_err = 1, read_enb = 0, FSM back in IDLE.
- Reset asserted during payload, then a fresh 8'h22 packet → pkt_count = 1, err_count = 0; enable = 0 with vld_out high → no pops.
